// File: rtl/sparse_pkg.sv
// Shared types and timing constants for the sparse systolic feed controller.
// Build option: define SPARSE_FEED_SKEW_EN to skew lane k by k cycles (diagonal wavefront).
package sparse_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_INDEX_SIZE = 3;
  localparam int DEF_N          = 8;
  localparam int DEF_MAX_NNZ    = 8;

  typedef struct packed {
    logic [DEF_INDEX_SIZE-1:0] index;
    logic [DEF_DATA_WIDTH-1:0] data;
  } lane_entry_t;

  function automatic int skew_f(input int k);
`ifdef SPARSE_FEED_SKEW_EN
    return k;
`else
    return 0;
`endif
  endfunction

  // With skew, the last lane needs N-1 extra cycles to drain its buffer.
  function automatic int stream_len_f(input int max_nnz, input int n);
`ifdef SPARSE_FEED_SKEW_EN
    return max_nnz + n - 1;
`else
    return max_nnz;
`endif
  endfunction

  function automatic int drain_len_f(input int n);
    return 2 * n;
  endfunction

  localparam int STREAM_LEN = stream_len_f(DEF_MAX_NNZ, DEF_N);
  localparam int DRAIN_LEN  = drain_len_f(DEF_N);

endpackage

// File: rtl/sparse_feed_ctrl_if.sv
// Load handshake and array-edge feed bundle for sparse_feed_ctrl.
interface sparse_feed_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_SIZE = 3,
  parameter int N          = 8
);
  logic                         start;
  logic                         ld_valid;
  logic                         ld_ready;
  logic                         ld_side;
  logic [$clog2(N)-1:0]         ld_lane;
  logic [DATA_WIDTH-1:0]        ld_data;
  logic [INDEX_SIZE-1:0]        ld_index;
  logic [N*DATA_WIDTH-1:0]      up_data;
  logic [N*INDEX_SIZE-1:0]      up_index;
  logic [N*DATA_WIDTH-1:0]      left_data;
  logic [N*INDEX_SIZE-1:0]      left_index;
  logic                         busy;
  logic                         done;
  logic                         ld_err;

  modport master (
    output start, ld_valid, ld_side, ld_lane, ld_data, ld_index,
    input  ld_ready, up_data, up_index, left_data, left_index, busy, done, ld_err
  );

  modport slave (
    input  start, ld_valid, ld_side, ld_lane, ld_data, ld_index,
    output ld_ready, up_data, up_index, left_data, left_index, busy, done, ld_err
  );
endinterface

// File: rtl/sparse_lane_buf.sv
// One lane's sparse entry buffer: ordered append with legality check and a read mux for entry e.
module sparse_lane_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_SIZE = 3,
  parameter int MAX_NNZ    = 8,
  parameter int E_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [INDEX_SIZE-1:0] i_index,
  input  logic                  i_ev,
  input  logic [E_W-1:0]        i_e,
  output logic                  o_ok,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [INDEX_SIZE-1:0] o_index
);
  localparam int L_W = $clog2(MAX_NNZ + 1);

  logic [L_W-1:0]        r_len;
  logic [INDEX_SIZE-1:0] r_last;
  logic [DATA_WIDTH-1:0] r_dat [MAX_NNZ];
  logic [INDEX_SIZE-1:0] r_idx [MAX_NNZ];
  logic                  w_push;

  // Indices strictly increase within a lane; zero data is reserved as the PE end marker.
  assign o_ok = (r_len != L_W'(MAX_NNZ)) && (i_data != '0) &&
                ((r_len == '0) || (i_index > r_last));
  assign w_push = i_wr & o_ok & ~i_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_len <= '0;
    else if (i_clr)  r_len <= '0;
    else if (w_push) r_len <= r_len + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_last <= i_index;
      for (int i = 0; i < MAX_NNZ; i++) begin
        if (r_len == L_W'(i)) begin
          r_dat[i] <= i_data;
          r_idx[i] <= i_index;
        end
      end
    end
  end

  always_comb begin
    o_data  = '0;
    o_index = '0;
    for (int i = 0; i < MAX_NNZ; i++) begin
      if (i_ev && (i_e == E_W'(i)) && (r_len > L_W'(i))) begin
        o_data  = r_dat[i];
        o_index = r_idx[i];
      end
    end
  end
endmodule

// File: rtl/sparse_feed_ctrl.sv
// Sparse operand feeder for an N x N systolic array: load 2N lane buffers, then stream them.
// Build option: SPARSE_FEED_SKEW_EN delays lane k by k cycles inside the block.
module sparse_feed_ctrl
  import sparse_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_SIZE = 3,
  parameter int N          = 8,
  parameter int MAX_NNZ    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sparse_feed_ctrl_if.slave bus
);
  localparam int SLEN   = stream_len_f(MAX_NNZ, N);
  localparam int DLEN   = drain_len_f(N);
  localparam int T_W    = $clog2(SLEN + 1);
  localparam int D_W    = $clog2(DLEN);
  localparam int LANE_W = $clog2(N);

  state_t         r_state;
  logic [T_W-1:0] r_t;
  logic [D_W-1:0] r_d;
  logic           r_ld_ready;
  logic           r_busy;
  logic           r_done;
  logic           r_ld_err;

  logic                 w_acc;
  logic                 w_bad;
  logic                 w_clr;
  logic                 w_stream;
  logic [2*N-1:0]       w_hit;
  logic [2*N-1:0]       w_ok;
  logic [2*N-1:0][DATA_WIDTH-1:0] w_rd_dat;
  logic [2*N-1:0][INDEX_SIZE-1:0] w_rd_idx;
  logic [2*N-1:0][DATA_WIDTH-1:0] r_feed_dat_p1;
  logic [2*N-1:0][INDEX_SIZE-1:0] r_feed_idx_p1;

  assign w_acc    = bus.ld_valid & r_ld_ready;
  assign w_bad    = w_acc & ~(|(w_hit & w_ok));
  assign w_clr    = (r_state == S_IDLE);
  assign w_stream = (r_state == S_STREAM);

  // Lanes 0..N-1 feed the top edge, N..2N-1 the left edge.
  for (genvar g = 0; g < 2 * N; g++) begin : g_lane
    localparam bit SIDE = (g >= N);
    localparam int K    = g % N;
    localparam int SK   = skew_f(K);

    logic           w_ev;
    logic [T_W-1:0] w_e;

    if (SK == 0) begin : g_noskew
      assign w_ev = w_stream;
    end else begin : g_skew
      assign w_ev = w_stream && (r_t >= T_W'(SK));
    end
    assign w_e      = r_t - T_W'(SK);
    assign w_hit[g] = (bus.ld_side == SIDE) && (bus.ld_lane == LANE_W'(K));

    sparse_lane_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .INDEX_SIZE (INDEX_SIZE),
      .MAX_NNZ    (MAX_NNZ),
      .E_W        (T_W)
    ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_clr),
      .i_wr    (w_acc & w_hit[g]),
      .i_data  (bus.ld_data),
      .i_index (bus.ld_index),
      .i_ev    (w_ev),
      .i_e     (w_e),
      .o_ok    (w_ok[g]),
      .o_data  (w_rd_dat[g]),
      .o_index (w_rd_idx[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_t        <= '0;
      r_d        <= '0;
      r_ld_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ld_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_LOAD;
          r_ld_ready <= 1'b1;
          r_ld_err   <= 1'b0;
        end
        S_LOAD: begin
          if (w_bad) r_ld_err <= 1'b1;
          if (bus.start) begin
            r_state    <= S_STREAM;
            r_t        <= '0;
            r_ld_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_STREAM: begin
          if (r_t == T_W'(SLEN - 1)) begin
            r_state <= S_DRAIN;
            r_d     <= '0;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_d == D_W'(DLEN - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_d <= r_d + 1'b1;
            // done is registered, so raise it one count early to land on the last drain cycle.
            if (r_d == D_W'(DLEN - 2)) r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---- feed register stage (p1): state/counter to edge outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feed_dat_p1 <= '0;
      r_feed_idx_p1 <= '0;
    end else begin
      r_feed_dat_p1 <= w_rd_dat;
      r_feed_idx_p1 <= w_rd_idx;
    end
  end

  assign bus.up_data    = r_feed_dat_p1[N-1:0];
  assign bus.up_index   = r_feed_idx_p1[N-1:0];
  assign bus.left_data  = r_feed_dat_p1[2*N-1:N];
  assign bus.left_index = r_feed_idx_p1[2*N-1:N];
  assign bus.ld_ready   = r_ld_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.ld_err     = r_ld_err;
endmodule
